muldiv_hilo_unit: RTL
=====================

# muldiv_hilo_unit

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO on the two ALU operands. MULT and MULTU use iterative shift-add; DIV and DIVU use restoring division. It sits beside the single-cycle ALU in EX and drives the hazard unit through `busy`.

## Interface
Parameters:
- `ITER`, 32: iteration count; must equal operand width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request valid; sampled only in IDLE.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x reserved, ignored.
- `opA` in 32: rs value (multiplicand or dividend; MTHI/MTLO source).
- `opB` in 32: rt value (multiplier or divisor).
- `flush` in 1: abort the in-flight operation (exception or branch squash).
- `busy` out 1: operation in RUN or FIX; the pipeline stalls MFHI, MFLO and new muldiv ops while high.
- `done` out 1: one-cycle pulse in the cycle HI/LO are written by a mul/div.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- Reset (async, `rst_n`=0): state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0. Asserting reset mid-operation discards it.
- **IDLE**
  - `start` with op MTHI or MTLO: `hi` or `lo` takes `opA` at the next edge. No busy, no done.
  - `start` with op mul/div:
    - Latch sign flags.
    - Signed ops load magnitudes |opA| and |opB|.
    - Clear the 64-bit accumulator and set counter=0.
    - Go to RUN.
- **RUN**
  - One iteration per cycle; counter increments.
  - Multiply: if multiplier LSB is 1, add multiplicand to the upper half; then shift right.
  - Divide: shift the remainder/quotient pair left, trial-subtract the divisor, and set the quotient bit when the result is non-negative.
  - When counter reaches `ITER`-1, go to FIX.
- **FIX** (1 cycle)
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ. The remainder takes the sign of the dividend.
  - Write at the edge ending FIX: `{hi,lo}` = product, or `hi`=remainder and `lo`=quotient.
  - `done`=1 during FIX; return to IDLE.
- **Divide by zero:** full latency. Result is `lo`=32'hFFFFFFFF and `hi`=dividend. For signed ops, sign fixing applies to the magnitude results.
- **Overflow:** DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000 and `hi`=0. All arithmetic is 32 bits modulo.
- **`start` outside IDLE:** ignored, including MTHI and MTLO. The hazard unit guarantees this does not happen; it is not an error.
- **`flush` in RUN or FIX:** next state IDLE. HI/LO are unchanged and `done` is not asserted in that cycle.
- **`flush` and `start` in the same IDLE cycle:** flush wins; the request is dropped. This applies to MTHI and MTLO too.

## Timing
- `busy` is registered; it rises at the edge that accepts `start`.
- Mul/div latency:
  - Edge E0 accepts the request.
  - RUN occupies `ITER` cycles, then FIX occupies 1 cycle.
  - The new `hi`/`lo` are visible after edge E0+`ITER`+1 (33 cycles for `ITER`=32).
  - `busy` is high for exactly `ITER`+1 cycles and falls at that same edge.
- `done` is combinationally equal to (state==FIX && !flush).
- Back-to-back: the cycle after FIX is IDLE, so a new `start` is accepted there.
- MTHI/MTLO latency: 1 edge.
- `hi` and `lo` are direct register outputs; no read bypass.

## Structure
- Add to shared `ISA.v`:
  - `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO` op encodings.
  - `MD_OP` width macro.
  - State encodings `MD_IDLE`, `MD_RUN`, `MD_FIX`.
- Sub-module `muldiv_iter_step`: combinational single-iteration step (shift-add or shift-subtract) on {acc[63:0], operand, mode}. The top level holds the FSM, counter, sign fix and HI/LO registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001 exactly 33 cycles after the accept edge; `busy` high for 33 cycles; `done` pulses once.
- MULT −3 (0xFFFFFFFD) × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 5 / 0 → `hi`=5, `lo`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Preload with MTHI 0x1234, MTLO 0x5678, then MULT 9×9. Assert `flush` on RUN cycle 10 → `busy` low next cycle, `done` never high, `hi`/`lo` stay 0x1234/0x5678.
- While `busy`, drive MTLO 0xAAAA → ignored; final `lo` equals the mul result. `flush` together with `start` in IDLE → no state change.
- Drop `rst_n` mid-DIVU, asynchronously between edges → `busy`, `done`, `hi` and `lo` go to 0 immediately. After release, a fresh DIVU 100 / 7 gives `lo`=14, `hi`=2.

Source files
------------

// File: rtl/muldiv_hilo_unit_pkg.sv
// muldiv_hilo_unit_pkg: shared encodings and types for the HI/LO multiply/divide unit.
//   - MD_* op encodings and operand/op widths
//   - MD_IDLE/MD_RUN/MD_FIX sequencer state encodings
//   - md_ctx_t: sign-fix context latched when an operation is accepted
//   - md_abs(): conditional two's-complement magnitude
package muldiv_hilo_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'b000;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'b001;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'b010;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'b011;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'b100;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'b101;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_RUN  = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;

  // Context carried from accept to FIX
  typedef struct packed {
    logic is_div;   // divide (1) or multiply (0)
    logic neg_res;  // negate product / quotient (operand signs differ, signed op)
    logic neg_rem;  // negate remainder (dividend negative, signed op)
  } md_ctx_t;

  // Magnitude of x when neg is set; 0x80000000 maps to itself, which is correct as unsigned
  function automatic logic [XLEN-1:0] md_abs(input logic [XLEN-1:0] x, input logic neg);
    return neg ? XLEN'(-x) : x;
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// muldiv_iter_step: one combinational iteration of the multiply/divide datapath.
//   acc      in  64 : accumulator {upper, lower}
//   operand  in  32 : multiplicand (mul) or divisor (div)
//   mode_div in   1 : 1 = restoring-divide step, 0 = shift-add multiply step
//   step_c   out 64 : accumulator after this iteration
// Multiply: lower half holds the multiplier, product grows in from the top.
// Divide:   lower half holds the dividend, shifted out into the remainder while quotient bits shift in.
module muldiv_iter_step
  import muldiv_hilo_unit_pkg::*;
(
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              mode_div,
  output logic [2*XLEN-1:0] step_c
);

  logic [XLEN:0] sum_c;     // upper half plus optional multiplicand, with carry
  logic [XLEN:0] rem_sh_c;  // remainder after the left shift; needs one extra bit
  logic          ge_c;      // trial subtraction is non-negative

  assign sum_c    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
  assign rem_sh_c = acc[2*XLEN-1:XLEN-1];
  assign ge_c     = (rem_sh_c >= {1'b0, operand});

  // Select the iteration for the current mode
  always_comb begin
    step_c = {sum_c, acc[XLEN-1:1]};
    if (mode_div) begin
      if (ge_c) begin
        // Difference is below the divisor, so it fits in XLEN bits
        step_c = {XLEN'(rem_sh_c - {1'b0, operand}), acc[XLEN-2:0], 1'b1};
      end else begin
        step_c = {acc[2*XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
//   clk, rst_n     : clock, async active-low reset
//   start, op      : request valid / op code (sampled only in IDLE)
//   opA, opB       : rs / rt operands
//   flush          : abort in-flight op; drops a same-cycle request in IDLE
//   busy           : high while in RUN or FIX (registered)
//   done           : high during FIX unless flushed (combinational)
//   hi, lo         : HI/LO registers
// Signed ops run on magnitudes; signs are restored in the single FIX cycle.
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int unsigned ITER = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [XLEN-1:0]    opA,
  input  logic [XLEN-1:0]    opB,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    hi,
  output logic [XLEN-1:0]    lo
);

  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  logic [1:0]        state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [2*XLEN-1:0] acc_q, acc_nxt;
  logic [XLEN-1:0]   opnd_q, opnd_nxt;
  md_ctx_t           ctx_q, ctx_nxt;
  logic [XLEN-1:0]   hi_nxt, lo_nxt;
  logic [2*XLEN-1:0] step_c;
  logic [2*XLEN-1:0] fix_c;
  logic              neg_a_c, neg_b_c;

  // op[0]=0 selects the signed variant for mul/div
  assign neg_a_c = ~op[0] & opA[XLEN-1];
  assign neg_b_c = ~op[0] & opB[XLEN-1];

  muldiv_iter_step u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .mode_div (ctx_q.is_div),
    .step_c   (step_c)
  );

  // Sign restoration of the finished magnitude result
  always_comb begin
    fix_c = acc_q;
    if (ctx_q.is_div) begin
      fix_c[XLEN-1:0]      = ctx_q.neg_res ? XLEN'(-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
      fix_c[2*XLEN-1:XLEN] = ctx_q.neg_rem ? XLEN'(-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    end else if (ctx_q.neg_res) begin
      fix_c = (2*XLEN)'(-acc_q);
    end
  end

  // Next-state and datapath-next logic
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    acc_nxt   = acc_q;
    opnd_nxt  = opnd_q;
    ctx_nxt   = ctx_q;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          case (op)
            MD_MTHI: hi_nxt = opA;
            MD_MTLO: lo_nxt = opA;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              ctx_nxt.is_div  = op[1];
              ctx_nxt.neg_res = neg_a_c ^ neg_b_c;
              ctx_nxt.neg_rem = neg_a_c;
              if (op[1]) begin
                opnd_nxt = md_abs(opB, neg_b_c);
                acc_nxt  = {{XLEN{1'b0}}, md_abs(opA, neg_a_c)};
              end else begin
                opnd_nxt = md_abs(opA, neg_a_c);
                acc_nxt  = {{XLEN{1'b0}}, md_abs(opB, neg_b_c)};
              end
              cnt_nxt   = '0;
              state_nxt = MD_RUN;
            end
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_nxt = MD_IDLE;
        end else begin
          acc_nxt = step_c;
          cnt_nxt = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_nxt = MD_FIX;
          end
        end
      end
      MD_FIX: begin
        state_nxt = MD_IDLE;
        if (!flush) begin
          hi_nxt = fix_c[2*XLEN-1:XLEN];
          lo_nxt = fix_c[XLEN-1:0];
        end
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  assign done = (state_q == MD_FIX) && !flush;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Datapath, HI/LO and busy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      ctx_q  <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      acc_q  <= acc_nxt;
      opnd_q <= opnd_nxt;
      ctx_q  <= ctx_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      busy   <= (state_nxt != MD_IDLE);
    end
  end

endmodule
